uart_rx_sipo: RTL
=================

// Module: uart_rx_sipo
// PURPOSE
//  UART receive path: complement of the 8-bit PISO transmit shifter. Samples an
//  asynchronous serial line and detects start/stop framing. Shifts data bits
//  LSB-first into an 8-bit serial-in/parallel-out register. Presents each byte
//  with a one-cycle valid strobe to the host side of the UART.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per bit period; must be even and >= 4
//  DATA_BITS     8   data bits per frame; no parity, exactly one stop bit
// PORTS
//  clk          in   1          system clock; all logic on the rising edge
//  rst          in   1          synchronous, active-high reset
//  serial_in    in   1          async RX line; idles high
//  data_out     out  DATA_BITS  last good byte; holds until the next good frame
//  data_valid   out  1          1-cycle pulse when data_out updates
//  framing_err  out  1          1-cycle pulse when the stop bit samples 0
//  busy         out  1          high in every state except IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, data_out=0, data_valid=0, framing_err=0, busy=0.
//    Synchronizer flops reset to 1. Bit and clock counters reset to 0.
//  - serial_in passes through a 2-FF synchronizer to give rx_s. All decisions
//    use rx_s, so there is 2 clk of input latency.
//  - IDLE: when rx_s=0, go to START and clear cnt.
//  - START: count to CLKS_PER_BIT/2-1 (mid-bit).
//      If rx_s=0 there, go to DATA with cnt=0 and bit_idx=0.
//      If rx_s=1 there, treat it as a glitch and return to IDLE. No strobe.
//  - DATA: at each cnt==CLKS_PER_BIT-1, shift rx_s into the shifter from the
//    MSB side, so the first bit lands at bit 0 after DATA_BITS shifts.
//    Increment bit_idx at the same point. After sample DATA_BITS-1, go to STOP.
//  - STOP: at cnt==CLKS_PER_BIT-1, sample rx_s.
//      1: load data_out from the shifter, pulse data_valid next cycle, go to IDLE.
//      0: pulse framing_err, leave data_out unchanged, go to WAIT_IDLE.
//  - WAIT_IDLE: stay until rx_s=1 (break or stuck-low line), then go to IDLE.
//    A new start bit is never detected while rx_s stays low.
//  - data_valid and framing_err are mutually exclusive. Each is high for
//    exactly one cycle per frame.
//  - Latency: the data_valid rising edge comes 1 clk after the stop-bit
//    mid-sample. That is about 9.5*CLKS_PER_BIT + 3 clk after the start-bit
//    falling edge on serial_in.
//  - Back-to-back frames: IDLE is re-entered at stop-bit mid-point. A start edge
//    half a bit later is accepted with no lost frame.
//  - cnt is $clog2(CLKS_PER_BIT) bits and wraps to 0 on every sample point.
//    bit_idx is $clog2(DATA_BITS+1) bits.
//  - rst asserted mid-frame: abort immediately to the reset values. The partial
//    byte is discarded and no strobe is issued.
// STRUCTURE
//  - Shared package/include uart_defs: state encodings
//    (IDLE, START, DATA, STOP, WAIT_IDLE) as localparams; UART_DATA_BITS=8.
//  - Sub-module sipo_8bit (clk, rst, shift_en, serial_in, parallel_out): the
//    shifter, mirroring piso_8bit on the TX side.
//  - The top level holds the synchronizer, the FSM, the counters and the output
//    registers.
// TESTING  (CLKS_PER_BIT=16; frames driven LSB-first: 1 start, 8 data, 1 stop)
//  1. Frame with byte 8'h8F -> one data_valid pulse, data_out=8'h8F,
//     framing_err=0, busy low after the stop-bit mid-sample.
//  2. Back-to-back frames 8'h00 then 8'hFF, with no idle beyond the stop bit ->
//     two data_valid pulses; data_out=8'h00 then 8'hFF.
//  3. Low glitch of 5 clk on an idle line -> return to IDLE at mid-bit;
//     no data_valid, no framing_err.
//  4. Frame 8'hA5 with stop bit driven 0, then line held low for 3 bit times ->
//     framing_err pulse once; data_out keeps its prior value. The next valid
//     frame 8'h3C is received correctly.
//  5. rst pulsed during data bit 4 of frame 8'h55 -> all outputs return to 0.
//     The following frame 8'hC3 gives data_out=8'hC3.
//  6. Loopback from piso_8bit (same clk, matching bit timing), parallel_in =
//     8'b10001111 -> data_out equals parallel_in.

Source files
------------

// File: rtl/uart_rx_sipo_pkg.sv
// Shared definitions for the UART receive path: FSM state encodings,
// default frame width and a small state-classification helper.
package uart_rx_sipo_pkg;

   // Default number of data bits per frame (no parity, one stop bit)
   localparam int UART_DATA_BITS = 8;

   // Receiver FSM encodings, kept as plain constants so older tools can
   // share them with the transmit side
   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_DATA      = 3'd2;
   localparam logic [2:0] S_STOP      = 3'd3;
   localparam logic [2:0] S_WAIT_IDLE = 3'd4;

   // The receiver is busy in every state except IDLE
   function automatic logic state_is_busy(input logic [2:0] state);
      return (state != S_IDLE);
   endfunction

endpackage

// File: rtl/uart_rx_sipo_if.sv
// Bundle between the serial line, the receiver and the host side.
// master: the receiver (consumes the line, produces bytes and strobes).
// slave : the host/line side (drives the line, consumes bytes and strobes).
interface uart_rx_sipo_if
   import uart_rx_sipo_pkg::*;
#(
   parameter int DATA_BITS = UART_DATA_BITS
);

   logic                 serial_in;
   logic [DATA_BITS-1:0] data_out;
   logic                 data_valid;
   logic                 framing_err;
   logic                 busy;

   modport master (
      input  serial_in,
      output data_out,
      output data_valid,
      output framing_err,
      output busy
   );

   modport slave (
      output serial_in,
      input  data_out,
      input  data_valid,
      input  framing_err,
      input  busy
   );

endinterface

// File: rtl/uart_rx_sipo_sipo.sv
// Serial-in/parallel-out shifter, the receive-side mirror of piso_8bit.
// Bits enter at the MSB and move toward bit 0, so with LSB-first framing
// the first received bit ends up at bit 0 after WIDTH shifts.
module sipo_8bit
   import uart_rx_sipo_pkg::*;
#(
   parameter int WIDTH = UART_DATA_BITS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift_en,
   input  logic             serial_in,
   output logic [WIDTH-1:0] parallel_out
);

   logic [WIDTH-1:0] shreg_q;
   logic [WIDTH-1:0] shreg_d;

   // Next-state: shift one bit in from the MSB side when enabled
   always_comb begin
      shreg_d = shreg_q;
      if (shift_en) begin
         shreg_d = {serial_in, shreg_q[WIDTH-1:1]};
      end
   end

   // Shift register state with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_q <= '0;
      end else begin
         shreg_q <= shreg_d;
      end
   end

   assign parallel_out = shreg_q;

endmodule

// File: rtl/uart_rx_sipo.sv
// UART receiver: 2-FF line synchronizer, framing FSM with mid-bit
// sampling, bit/clock counters, SIPO shifter and registered host outputs.
// CLKS_PER_BIT is expected to be even and at least 4 so that the mid-bit
// point CLKS_PER_BIT/2-1 is a meaningful count.
module uart_rx_sipo
   import uart_rx_sipo_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = UART_DATA_BITS
) (
   input  logic           clk,
   input  logic           rst,
   uart_rx_sipo_if.master rx
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS + 1);

   // Sample points: mid start bit, and one full bit period thereafter
   localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   logic [1:0]           sync_q, sync_d;
   logic [2:0]           state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 shift_en;
   logic                 rx_s;
   logic [DATA_BITS-1:0] shift_data;

   // Line synchronizer: the raw line enters at bit 0, rx_s leaves at bit 1
   always_comb begin
      sync_d = {sync_q[0], rx.serial_in};
   end

   assign rx_s = sync_q[1];

   // Framing FSM, counters and output register next-state logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
      shift_en  = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rx_s) begin
               state_d = S_START;
            end
         end

         S_START: begin
            if (cnt_q == CNT_MID) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               // A line that is high again at mid-bit was only a glitch
               state_d   = rx_s ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d     = '0;
               shift_en  = 1'b1;
               bit_idx_d = bit_idx_q + 1'b1;
               if (bit_idx_q == BIT_LAST) begin
                  state_d = S_STOP;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  // Good stop bit: publish the byte; IDLE is re-entered at
                  // the stop-bit midpoint so back-to-back frames are caught
                  data_d  = shift_data;
                  valid_d = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  // Bad stop bit: keep the previous byte and wait for the
                  // line to return high before hunting for a new start
                  ferr_d  = 1'b1;
                  state_d = S_WAIT_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_WAIT_IDLE: begin
            cnt_d = '0;
            if (rx_s) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State registers; reset aborts any frame in progress immediately
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q    <= 2'b11;
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

   sipo_8bit #(
      .WIDTH(DATA_BITS)
   ) u_sipo (
      .clk         (clk),
      .rst         (rst),
      .shift_en    (shift_en),
      .serial_in   (rx_s),
      .parallel_out(shift_data)
   );

   assign rx.data_out    = data_q;
   assign rx.data_valid  = valid_q;
   assign rx.framing_err = ferr_q;
   assign rx.busy        = state_is_busy(state_q);

endmodule
